// File: rtl/led_sched_pkg.sv
// rtl/led_sched_pkg.sv - shared types and constants for the LED step scheduler
//
// Purpose: FSM state encoding, cycler colour constants and counter saturation value
//          shared by led_step_scheduler and its bench.
// Ports:   none (package).
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    AUTO   = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

  localparam logic [2:0] COL_OFF   = 3'b000;
  localparam logic [2:0] COL_FIRST = 3'b001;
  localparam logic [2:0] COL_LAST  = 3'b110;

  localparam logic [3:0] CNT_MAX = 4'd15;

endpackage

// File: rtl/led_step_scheduler_btn_debounce.sv
// rtl/led_step_scheduler_btn_debounce.sv - push-button synchroniser plus stability-counter debouncer
//
// Purpose: brings the asynchronous button into the clock domain with two flops, then only
//          lets the debounced level follow once DEBOUNCE_CYCLES consecutive synchronised
//          samples disagree with it.
// Ports:   clk  - clock
//          rst  - synchronous active-high reset
//          din  - raw asynchronous button level
//          dout - debounced level (resets to 0)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      // cnt counts consecutive samples that differ from dout; any agreeing sample restarts it
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_step_scheduler.sv
// rtl/led_step_scheduler.sv - step pulse scheduler for the LED colour cycler
//
// Purpose: turns button presses into cycler step pulses, either one per press (manual) or
//          one every `period` cycles (auto), counts completed colour cycles from the
//          colour feedback and stops after n_cycles of them.
// Ports:   clk, rst      - clock, synchronous active-high reset
//          btn_raw       - asynchronous push-button
//          mode          - 0 manual / 1 auto, sampled on a press
//          period        - auto step interval (0 behaves as 1)
//          n_cycles      - colour cycles before stopping, 0 = run forever
//          colour        - cycler colour feedback
//          step          - registered one-cycle pulse to the cycler button input
//          busy, done    - state flags (MANUAL/AUTO, DONE)
//          cycle_cnt     - completed colour cycles, saturating at 15
// Config:  LED_SCHED_DEBOUNCE_EN - when defined, btn_debounce filters the button;
//          otherwise only a 2-flop synchroniser is used and bounces become presses.
module led_step_scheduler
  import led_sched_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PERIOD_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_raw,
  input  logic                mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [3:0]          n_cycles,
  input  logic [2:0]          colour,
  output logic                step,
  output logic                busy,
  output logic                done,
  output logic [3:0]          cycle_cnt
);

  logic btn_db;
  logic btn_db_q;
  logic press;

`ifdef LED_SCHED_DEBOUNCE_EN
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .din (btn_raw),
    .dout(btn_db)
  );
`else
  logic sync1;
  logic sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign btn_db = sync2;
`endif

  assign press = btn_db & ~btn_db_q;

  sched_state_t        state;
  sched_state_t        state_n;
  logic [PERIOD_W-1:0] timer;
  logic [PERIOD_W-1:0] timer_n;
  logic [PERIOD_W-1:0] period_eff;
  logic                step_n;
  logic [3:0]          cnt_n;
  logic [3:0]          cnt_inc;
  logic                wrap;
  logic                busy_n;
  logic                done_n;

  assign period_eff = (period == '0) ? PERIOD_W'(1) : period;
  assign cnt_inc    = (cycle_cnt == CNT_MAX) ? CNT_MAX : cycle_cnt + 4'd1;
  // step is consumed by the cycler on this edge, so colour is still the pre-step value
  assign wrap       = step && (colour == COL_LAST);

  always_comb begin
    state_n = state;
    timer_n = timer;
    step_n  = 1'b0;
    cnt_n   = cycle_cnt;
    busy_n  = 1'b0;
    done_n  = 1'b0;

    case (state)
      IDLE, MANUAL: begin
        if (press) begin
          if (mode) begin
            state_n = AUTO;
            timer_n = period_eff;
          end else begin
            state_n = MANUAL;
            step_n  = 1'b1;
          end
        end
      end
      AUTO: begin
        // a press pauses even if the timer expires on the same cycle
        if (press) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (timer <= PERIOD_W'(1)) begin
          step_n  = 1'b1;
          timer_n = period_eff;
        end else begin
          timer_n = timer - PERIOD_W'(1);
        end
      end
      DONE: begin
        if (press) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    // the wrap step itself is already out; reaching the target suppresses any further step
    if (wrap) begin
      cnt_n = cnt_inc;
      if ((n_cycles != 4'd0) && (cnt_inc == n_cycles)) begin
        state_n = DONE;
        step_n  = 1'b0;
        timer_n = '0;
      end
    end

    busy_n = (state_n == MANUAL) || (state_n == AUTO);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      step      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cycle_cnt <= '0;
      btn_db_q  <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      step      <= step_n;
      busy      <= busy_n;
      done      <= done_n;
      cycle_cnt <= cnt_n;
      btn_db_q  <= btn_db;
    end
  end

endmodule

// File: tb/tb_led_step_scheduler.sv
// tb/tb_led_step_scheduler.sv - self-checking bench for led_step_scheduler with an attached cycler model
module tb_led_step_scheduler;

  localparam int DB = 4;
  localparam int PW = 8;
`ifdef LED_SCHED_DEBOUNCE_EN
  localparam int LAT   = 2 + DB;
  localparam bit DB_ON = 1'b1;
`else
  localparam int LAT   = 2;
  localparam bit DB_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_raw = 1'b0;
  logic          mode = 1'b0;
  logic [PW-1:0] period = '0;
  logic [3:0]    n_cycles = '0;
  logic [2:0]    colour = 3'b000;
  logic          step;
  logic          busy;
  logic          done;
  logic [3:0]    cycle_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int step_times[$];
  logic [2:0] step_cols[$];

  led_step_scheduler #(.DEBOUNCE_CYCLES(DB), .PERIOD_W(PW)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .mode(mode), .period(period),
    .n_cycles(n_cycles), .colour(colour), .step(step), .busy(busy), .done(done),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] cyc_next(input logic [2:0] c);
    return (c >= 3'd1 && c <= 3'd5) ? c + 3'd1 : 3'd1;
  endfunction

  // cycler: advances its colour on every step it receives
  always @(posedge clk) begin
    if (rst) colour <= 3'b000;
    else if (step === 1'b1) colour <= cyc_next(colour);
  end

  // step log: edge number that raised step, and the colour the cycler held at that time
  always @(negedge clk) begin
    if (step === 1'b1) begin
      step_times.push_back(cyc);
      step_cols.push_back(colour);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_raw = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    step_times.delete();
    step_cols.delete();
  endtask

  // hold the button until busy rises; e = edge of the state change or -1
  task automatic enter(output int e);
    btn_raw = 1'b1;
    e = -1;
    for (int k = 0; k < LAT + 6; k++) begin
      tick(1);
      if (busy === 1'b1) begin
        e = cyc;
        break;
      end
    end
    btn_raw = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++; if (step !== 1'b0) begin failures++; $display("FAIL reset_step got=%b want=0", step); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (cycle_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", cycle_cnt); end
    rst = 1'b0;
    tick(2);
    step_times.delete();
    step_cols.delete();
  endtask

  task automatic test_manual_press();
    int t0;
    logic exp_step;
    mode = 1'b0; n_cycles = 4'd0;
    t0 = cyc;
    btn_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      exp_step = ((cyc - t0 - 1) == LAT);
      checks++;
      if (step !== exp_step) begin
        failures++; $display("FAIL manual_step_edge%0d got=%b want=%b", cyc - t0 - 1, step, exp_step);
      end
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL manual_busy got=%b want=1", busy); end
    checks++; if (colour !== 3'b001) begin failures++; $display("FAIL manual_colour got=%b want=001", colour); end
    btn_raw = 1'b0;
    tick(LAT + 4);
    checks++;
    if (step_times.size() != 1) begin
      failures++; $display("FAIL manual_held_steps got=%0d want=1", step_times.size());
    end
  endtask

  task automatic test_bounce();
    int n;
    step_times.delete(); step_cols.delete();
    mode = 1'b0;
    for (int i = 0; i < 12; i++) begin
      btn_raw = ((i / 2) % 2 == 0);
      tick(1);
    end
    btn_raw = 1'b1;
    tick(LAT + 6);
    btn_raw = 1'b0;
    tick(LAT + 4);
    n = step_times.size();
    checks++;
    if (DB_ON ? (n != 1) : (n <= 1)) begin
      failures++; $display("FAIL bounce_steps got=%0d want=%s", n, DB_ON ? "1" : ">1");
    end
  endtask

  task automatic test_auto(input int p, input int n);
    int e, peff, k_exp, wraps, nsteps;
    logic [2:0] col;
    do_reset();
    mode = 1'b1; period = PW'(p); n_cycles = 4'(n);
    peff = (p == 0) ? 1 : p;
    enter(e);
    checks++; if (e < 0) begin failures++; $display("FAIL auto_entry p=%0d busy=%b want=1", p, busy); end
    col = 3'b000; wraps = 0; k_exp = 0;
    while (wraps < n) begin
      if (col == 3'b110) wraps++;
      col = cyc_next(col);
      k_exp++;
    end
    for (int k = 0; k < peff * (7 + 6 * n) + 50 && done !== 1'b1; k++) tick(1);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL auto_done p=%0d n=%0d got=%b want=1", p, n, done); end
    checks++;
    if (step_times.size() != k_exp) begin
      failures++; $display("FAIL auto_nsteps p=%0d n=%0d got=%0d want=%0d", p, n, step_times.size(), k_exp);
    end
    col = 3'b000;
    for (int i = 0; i < step_times.size() && i < k_exp; i++) begin
      checks++;
      if (step_times[i] != e + peff * (i + 1) || step_cols[i] !== col) begin
        failures++;
        $display("FAIL auto_step%0d edge=%0d col=%b want edge=%0d col=%b", i, step_times[i], step_cols[i], e + peff * (i + 1), col);
      end
      col = cyc_next(col);
    end
    checks++; if (cycle_cnt !== 4'(n)) begin failures++; $display("FAIL auto_cnt got=%0d want=%0d", cycle_cnt, n); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL auto_busy_done got=%b want=0", busy); end
    nsteps = step_times.size();
    tick(3 * peff + 5 + LAT);
    checks++;
    if (step_times.size() != nsteps) begin
      failures++; $display("FAIL auto_after_done steps got=%0d want=%0d", step_times.size(), nsteps);
    end
    btn_raw = 1'b1;
    tick(LAT + 2);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cycle_cnt !== 4'd0) begin
      failures++; $display("FAIL done_press done=%b busy=%b cnt=%0d want 0/0/0", done, busy, cycle_cnt);
    end
    btn_raw = 1'b0;
    tick(LAT + 3);
  endtask

  task automatic test_pause_tie(input int p);
    int e, k, t, nset;
    logic [3:0] cb;
    do_reset();
    mode = 1'b1; period = PW'(p); n_cycles = 4'd0;
    enter(e);
    checks++; if (e < 0) begin failures++; $display("FAIL pause_entry busy=%b want=1", busy); end
    tick(LAT + 3);
    k = 1;
    while (e + k * p - 1 - LAT <= cyc) k++;
    t = e + k * p;
    nset = t - 1 - LAT;
    while (cyc < nset) tick(1);
    btn_raw = 1'b1;
    while (cyc < t - 1) tick(1);
    cb = cycle_cnt;
    tick(1);
    checks++; if (step !== 1'b0) begin failures++; $display("FAIL pause_step p=%0d got=%b want=0", p, step); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pause_busy got=%b want=0", busy); end
    checks++; if (cycle_cnt !== cb) begin failures++; $display("FAIL pause_cnt got=%0d want=%0d", cycle_cnt, cb); end
    tick(2 * p + 2);
    checks++;
    if (step_times.size() > 0 && step_times[step_times.size() - 1] >= t) begin
      failures++; $display("FAIL pause_no_steps last=%0d want<%0d", step_times[step_times.size() - 1], t);
    end
    btn_raw = 1'b0;
    tick(LAT + 3);
  endtask

  task automatic test_reset_midrun();
    int e, ns;
    do_reset();
    mode = 1'b1; period = PW'(1); n_cycles = 4'd0;
    enter(e);
    checks++; if (e < 0) begin failures++; $display("FAIL midrun_entry busy=%b want=1", busy); end
    tick(30);
    checks++; if (cycle_cnt == 4'd0) begin failures++; $display("FAIL midrun_cnt_before got=0 want>0"); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (step !== 1'b0 || busy !== 1'b0 || cycle_cnt !== 4'd0) begin
      failures++; $display("FAIL midrun_reset step=%b busy=%b cnt=%0d want 0/0/0", step, busy, cycle_cnt);
    end
    ns = step_times.size();
    tick(3);
    checks++; if (step_times.size() != ns) begin failures++; $display("FAIL midrun_idle_steps got=%0d want=%0d", step_times.size(), ns); end
    step_times.delete(); step_cols.delete();
    mode = 1'b0;
    btn_raw = 1'b1;
    tick(LAT + 3);
    checks++;
    if (busy !== 1'b1 || step_times.size() != 1) begin
      failures++; $display("FAIL midrun_restart busy=%b steps=%0d want 1/1", busy, step_times.size());
    end else begin
      checks++; if (step_cols[0] !== 3'b000) begin failures++; $display("FAIL midrun_restart_col got=%b want=000", step_cols[0]); end
    end
    btn_raw = 1'b0;
    tick(LAT + 3);
  endtask

  task automatic test_period_zero();
    int e, span, wraps;
    logic [2:0] col;
    do_reset();
    mode = 1'b1; period = '0; n_cycles = 4'd0;
    enter(e);
    checks++; if (e < 0) begin failures++; $display("FAIL p0_entry busy=%b want=1", busy); end
    tick(150);
    span = cyc - e;
    checks++; if (step_times.size() != span) begin failures++; $display("FAIL p0_steps got=%0d want=%0d", step_times.size(), span); end
    col = 3'b000; wraps = 0;
    for (int i = 0; i < step_times.size(); i++) begin
      if (col == 3'b110) wraps++;
      col = cyc_next(col);
    end
    if (step === 1'b1 && colour == 3'b110) wraps--;
    checks++;
    if (cycle_cnt !== 4'((wraps > 15) ? 15 : wraps)) begin
      failures++; $display("FAIL p0_cnt got=%0d want=%0d", cycle_cnt, (wraps > 15) ? 15 : wraps);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL p0_flags done=%b busy=%b want 0/1", done, busy);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d want finish before limit", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_manual_press();
    test_bounce();
    test_auto(3, 2);
    test_auto($urandom_range(1, 5), $urandom_range(1, 3));
    test_auto($urandom_range(0, 4), $urandom_range(1, 3));
    test_pause_tie(4);
    test_pause_tie($urandom_range(3, 7));
    test_reset_midrun();
    test_period_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
